// File: rtl/pipeline_exec_controller.sv
// ============================================================================
// Module   : pipeline_exec_controller
// Purpose  : Run/step/halt controller for a pipelined processor. Accepts
//            NOP/RUN/STEP/STOP commands, gates PC and pipeline-register
//            enables, detects a HALT opcode in the ID stage and drains
//            in-flight instructions before reporting HALTED.
// Ports    : i_clock, i_reset_n (async, active low)
//            i_cmd_valid, i_cmd[1:0], o_cmd_ready   - command handshake
//            i_id_valid, i_id_opcode                - ID-stage instruction
//            o_pc_enb, o_pipe_enb                   - pipeline enables
//            o_flush, o_step_done, o_halted         - registered status
//            o_busy, o_cycle_count                  - activity/statistics
// Config   : define PIPE_CYCLE_COUNT_EN to build the enabled-cycle counter;
//            otherwise o_cycle_count is tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipeline_exec_controller #(
    parameter int                   NB_OPCODE      = 6,
    parameter logic [NB_OPCODE-1:0] HALT_OPCODE    = 6'b011111,
    parameter int                   DRAIN_CYCLES   = 4,
    parameter int                   NB_CYCLE_COUNT = 32
) (
    input  logic                      i_clock,
    input  logic                      i_reset_n,
    input  logic                      i_cmd_valid,
    input  logic [1:0]                i_cmd,
    output logic                      o_cmd_ready,
    input  logic                      i_id_valid,
    input  logic [NB_OPCODE-1:0]      i_id_opcode,
    output logic                      o_pc_enb,
    output logic                      o_pipe_enb,
    output logic                      o_flush,
    output logic                      o_step_done,
    output logic                      o_halted,
    output logic                      o_busy,
    output logic [NB_CYCLE_COUNT-1:0] o_cycle_count
);

    // A drain length of zero still needs one cycle to reach HALTED.
    localparam int C_DRAIN_EFF = (DRAIN_CYCLES < 1) ? 1 : DRAIN_CYCLES;
    localparam int C_CNT_W     = $clog2(C_DRAIN_EFF + 1);

    localparam logic [C_CNT_W-1:0] c_drain_load = C_CNT_W'(C_DRAIN_EFF);
    localparam logic [C_CNT_W-1:0] c_drain_one  = C_CNT_W'(1);

    localparam logic [1:0] c_cmd_run  = 2'b01;
    localparam logic [1:0] c_cmd_step = 2'b10;
    localparam logic [1:0] c_cmd_stop = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RUN    = 3'd1,
        S_STEP   = 3'd2,
        S_DRAIN  = 3'd3,
        S_HALTED = 3'd4
    } state_t;

    state_t             r_state;
    logic [C_CNT_W-1:0] r_drain_cnt;
    logic               r_halted;
    logic               r_flush;
    logic               r_step_done;

    logic w_halt_hit;
    logic w_accept;
    logic w_stop;
    logic w_exec;

    assign w_halt_hit = i_id_valid & (i_id_opcode == HALT_OPCODE);
    assign w_exec     = (r_state == S_RUN) | (r_state == S_STEP);

    assign o_cmd_ready = (r_state == S_IDLE) | (r_state == S_RUN) | (r_state == S_HALTED);
    assign w_accept    = i_cmd_valid & o_cmd_ready;
    assign w_stop      = w_accept & (i_cmd == c_cmd_stop);

    // A HALT in ID must freeze the PC in the very cycle it is seen.
    assign o_pc_enb    = w_exec & ~w_halt_hit;
    assign o_pipe_enb  = w_exec | (r_state == S_DRAIN);
    assign o_busy      = o_pipe_enb;
    assign o_flush     = r_flush;
    assign o_step_done = r_step_done;
    assign o_halted    = r_halted;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state     <= S_IDLE;
            r_drain_cnt <= '0;
            r_halted    <= 1'b0;
            r_flush     <= 1'b0;
            r_step_done <= 1'b0;
        end else begin
            r_flush     <= 1'b0;
            r_step_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        case (i_cmd)
                            c_cmd_run:  r_state <= S_RUN;
                            c_cmd_step: r_state <= S_STEP;
                            c_cmd_stop: r_flush <= 1'b1;
                            default:    ;
                        endcase
                    end
                end
                S_RUN: begin
                    // HALT takes priority; a coincident STOP is swallowed.
                    if (w_halt_hit) begin
                        r_state     <= S_DRAIN;
                        r_drain_cnt <= c_drain_load;
                    end else if (w_stop) begin
                        r_state <= S_IDLE;
                    end
                end
                S_STEP: begin
                    r_step_done <= 1'b1;
                    if (w_halt_hit) begin
                        r_state     <= S_DRAIN;
                        r_drain_cnt <= c_drain_load;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_DRAIN: begin
                    if (r_drain_cnt <= c_drain_one) begin
                        r_state     <= S_HALTED;
                        r_halted    <= 1'b1;
                        r_drain_cnt <= '0;
                    end else begin
                        r_drain_cnt <= r_drain_cnt - c_drain_one;
                    end
                end
                S_HALTED: begin
                    // RUN and STEP are accepted but deliberately dropped.
                    if (w_stop) begin
                        r_state  <= S_IDLE;
                        r_halted <= 1'b0;
                        r_flush  <= 1'b1;
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_halted <= 1'b0;
                end
            endcase
        end
    end

`ifdef PIPE_CYCLE_COUNT_EN
    logic [NB_CYCLE_COUNT-1:0] r_cycle_count;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_cycle_count <= '0;
        end else if (r_flush) begin
            r_cycle_count <= '0;
        end else if (o_pipe_enb && (r_cycle_count != {NB_CYCLE_COUNT{1'b1}})) begin
            r_cycle_count <= r_cycle_count + 1'b1;
        end
    end

    assign o_cycle_count = r_cycle_count;
`else
    assign o_cycle_count = '0;
`endif

endmodule

`default_nettype wire

// File: doc/pipeline_exec_controller.md
PIPELINE_EXEC_CONTROLLER -- requirements
Module: pipeline_exec_controller

Interface
REQ-001 SHALL have parameter NB_OPCODE, default 6: width of the ID-stage opcode.
REQ-002 SHALL have parameter HALT_OPCODE, default 6'b011111: opcode that halts the processor.
REQ-003 SHALL have parameter DRAIN_CYCLES, default 4: cycles needed for in-flight instructions to retire after a HALT.
REQ-004 SHALL have parameter NB_CYCLE_COUNT, default 32: width of the cycle counter.
REQ-005 SHALL have one clock and an asynchronous, active-low reset; ports i_clock and i_reset_n.
REQ-006 i_clock  input  1  system clock; all state updates on the rising edge.
REQ-007 i_reset_n  input  1  asynchronous reset, active low.
REQ-008 i_cmd_valid  input  1  command present.
REQ-009 i_cmd  input  2  command: 00 NOP, 01 RUN, 10 STEP, 11 STOP.
REQ-010 o_cmd_ready  output  1  controller can accept a command; accepted = i_cmd_valid & o_cmd_ready.
REQ-011 i_id_valid  input  1  the ID stage holds a real instruction, not a bubble.
REQ-012 i_id_opcode  input  NB_OPCODE  opcode in the ID stage.
REQ-013 o_pc_enb  output  1  PC update enable.
REQ-014 o_pipe_enb  output  1  pipeline register enable.
REQ-015 o_flush  output  1  one-cycle pipeline-clear pulse.
REQ-016 o_step_done  output  1  one-cycle pulse marking step completion.
REQ-017 o_halted  output  1  processor halted.
REQ-018 o_busy  output  1  high in RUN, STEP and DRAIN.
REQ-019 o_cycle_count  output  NB_CYCLE_COUNT  count of enabled pipeline cycles.

Function
REQ-020 SHALL implement the FSM states IDLE, RUN, STEP, DRAIN and HALTED.
REQ-021 o_cmd_ready SHALL be 1 in IDLE, RUN and HALTED, and 0 in STEP and DRAIN; it is combinational from the state.
REQ-022 IDLE: o_pc_enb=o_pipe_enb=0; accepted RUN->RUN; accepted STEP->STEP; accepted STOP stays IDLE; NOP has no effect.
REQ-023 RUN: o_pipe_enb=1; o_pc_enb=1 unless halt_hit; an accepted STOP moves to IDLE the next cycle with no drain.
REQ-024 halt_hit SHALL be combinational: i_id_valid & (i_id_opcode==HALT_OPCODE); in RUN or STEP it forces o_pc_enb=0 in the same cycle and moves to DRAIN the next cycle.
REQ-025 If halt_hit and an accepted STOP coincide in RUN, halt_hit SHALL win; the STOP is consumed and ignored.
REQ-026 STEP: SHALL last exactly one cycle with o_pipe_enb=1 and o_pc_enb=~halt_hit, then go to IDLE, or to DRAIN if halt_hit.
REQ-027 o_step_done SHALL be registered and pulse 1 cycle in the cycle after STEP, including when STEP exits to DRAIN.
REQ-028 DRAIN: o_pc_enb=0, o_pipe_enb=1; on entry a down-counter loads DRAIN_CYCLES; the FSM stays exactly DRAIN_CYCLES cycles, then goes to HALTED.
REQ-029 DRAIN_CYCLES=0 SHALL be treated as 1.
REQ-030 HALTED: o_pc_enb=o_pipe_enb=0, o_halted=1; an accepted STOP moves to IDLE; RUN and STEP are consumed and dropped.
REQ-031 An accepted STOP in IDLE or HALTED SHALL produce a registered o_flush pulse for exactly 1 cycle, in the cycle after acceptance.
REQ-032 An accepted STOP in RUN SHALL NOT produce o_flush.
REQ-033 o_halted, o_flush and o_step_done SHALL be glitch-free registered outputs; o_pc_enb, o_pipe_enb, o_busy and o_cmd_ready are decoded from the state.

Reset
REQ-034 On i_reset_n=0 SHALL enter IDLE immediately (asynchronous), with the drain counter and o_cycle_count at 0.
REQ-035 Reset values: o_pc_enb=0, o_pipe_enb=0, o_flush=0, o_step_done=0, o_halted=0, o_busy=0, o_cmd_ready=1.
REQ-036 Reset asserted mid-DRAIN or mid-STEP SHALL abort the operation with no o_step_done and no o_flush pulse.

Configuration
REQ-037 Macro PIPE_CYCLE_COUNT_EN defined: o_cycle_count SHALL increment each cycle o_pipe_enb=1, saturate at all-ones, and clear to 0 on o_flush.
REQ-038 Macro PIPE_CYCLE_COUNT_EN undefined: o_cycle_count SHALL be tied to 0 and no counter register is synthesized.

Verification
REQ-039 Reset, then RUN with no HALT for 10 cycles -> o_pc_enb=o_pipe_enb=1 every cycle; with macro defined, o_cycle_count=10.
REQ-040 RUN, then i_id_valid=1 with i_id_opcode=6'b011111 at cycle N -> o_pc_enb=0 at N; DRAIN for 4 cycles with o_pipe_enb=1; o_halted=1 from N+5.
REQ-041 In IDLE, 3 STEP commands with no HALT -> 3 single-cycle o_pipe_enb pulses, each followed by an o_step_done pulse; o_cmd_ready=0 during each STEP.
REQ-042 In HALTED, send RUN, then STOP -> RUN dropped (state stays HALTED); STOP gives o_flush=1 for 1 cycle, then IDLE; o_cycle_count=0.
REQ-043 In RUN, HALT opcode and STOP in the same cycle -> DRAIN entered and no o_flush; then assert i_reset_n=0 during DRAIN -> all outputs at reset values immediately.
